// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding for the serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;
endpackage

// File: rtl/serial_subtractor_fs.sv
// fs_behavioral: combinational 1-bit full subtractor
module fs_behavioral (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bi, LSB first, one bit per cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bo
);
  localparam int CW = $clog2(WIDTH);
  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, dif_q, dif_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bo_q, bo_d;
  logic             fs_d, fs_bo, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  fs_behavioral u_fs (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d         = dif_q;
  assign bo        = bo_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    dif_d   = dif_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        a_d     = a;
        b_d     = b;
        brw_d   = bi;
        cnt_d   = '0;
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = fs_bo;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
        // Publish the result only when complete so d/bo hold the previous answer meanwhile.
        if (last) begin
          state_d = DONE;
          dif_d   = {fs_d, res_q[WIDTH-1:1]};
          bo_d    = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = brw_q ^ fs_bo;
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dif_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dif_q   <= dif_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bi = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] d;
  logic       bo;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif
  int checks = 0;
  int failures = 0;
  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bo        (bo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", 64'(n), 64'd8);
  endtask
  task automatic op(input logic [7:0] xa, input logic [7:0] xb, input logic xbi,
                    input logic [7:0] ed, input logic ebo, input logic eovf);
    @(negedge clk);
    a = xa;
    b = xb;
    bi = xbi;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 8'hxx;
    b = 8'hxx;
    check("shift_in_ready", 64'(in_ready), 64'd0);
    wait_result();
    check("d", 64'(d), 64'(ed));
    check("bo", 64'(bo), 64'(ebo));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 64'(ovf), 64'(eovf));
`else
    if (eovf === 1'bx) checks = checks;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("pop_out_valid", 64'(out_valid), 64'd0);
    check("pop_in_ready", 64'(in_ready), 64'd1);
    check("idle_d_hold", 64'(d), 64'(ed));
  endtask
  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_d", 64'(d), 64'd0);
    check("rst_bo", 64'(bo), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);
    op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    // Backpressure: hold out_ready low while a new operand set is offered.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    bi = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 a = 8'h09;
    b = 8'h02;
    wait_result();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_d", 64'(d), 64'h22);
      check("bp_bo", 64'(bo), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    check("rel_d", 64'(d), 64'h22);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("acc_in_ready", 64'(in_ready), 64'd0);
    wait_result();
    check("bp_next_d", 64'(d), 64'h07);
    check("bp_next_bo", 64'(bo), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    // Reset in the middle of SHIFT.
    @(negedge clk);
    a = 8'h44;
    b = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_d", 64'(d), 64'd0);
    check("arst_bo", 64'(bo), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    clrn = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_d", 64'(d), 64'd0);
    op(8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bi  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port d  output  WIDTH  difference a - b - bi, modulo 2^WIDTH.
REQ-012 SHALL have port bo  output  1  borrow-out (1 when a < b + bi, unsigned).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL assert in_ready only in IDLE; no same-cycle DONE->accept bypass.
REQ-015 SHALL, on in_valid && in_ready at an edge, latch a, b, bi, clear the bit counter, and enter SHIFT.
REQ-016 SHALL, in SHIFT, process one bit per cycle LSB first: diff bit = a0^b0^borrow; next borrow = (~a0&b0) | (~(a0^b0)&borrow); shift result in at MSB.
REQ-017 SHALL leave SHIFT after exactly WIDTH cycles, entering DONE; out_valid rises WIDTH cycles after the acceptance edge.
REQ-018 SHALL hold d, bo, ovf and out_valid stable in DONE until out_valid && out_ready, then return to IDLE.
REQ-019 SHALL keep d/bo at last result while IDLE; out_valid low outside DONE.
REQ-020 SHALL ignore a, b, bi, in_valid outside IDLE.
REQ-021 SHALL size the bit counter as $clog2(WIDTH) bits; terminal count WIDTH-1, no wrap beyond.

Reset
REQ-022 SHALL, when clrn is low, immediately force state IDLE, in_ready=1 after release, out_valid=0, d=0, bo=0, ovf=0, counter=0.
REQ-023 SHALL abort any in-flight operation on reset without producing a result.

Configuration
REQ-024 SHALL, with macro SERIAL_SUB_OVF_EN defined, add port ovf  output  1  signed two's-complement overflow (borrow into MSB XOR borrow out of MSB), valid with out_valid.
REQ-025 SHALL, without SERIAL_SUB_OVF_EN, omit port ovf and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place the FSM state enum (IDLE/SHIFT/DONE) and its encoding in shared package serial_sub_pkg.
REQ-027 SHALL instantiate one combinational 1-bit full-subtractor sub-module fs_behavioral (inputs a, b, bi; outputs d, bo) for the per-bit step.

Verification
REQ-028 SHALL check WIDTH=8: a=0x05, b=0x03, bi=0 -> d=0x02, bo=0, out_valid 8 cycles after accept.
REQ-029 SHALL check a=0x00, b=0x01, bi=0 -> d=0xFF, bo=1 (underflow wrap).
REQ-030 SHALL check a=0x10, b=0x0F, bi=1 -> d=0x00, bo=0; with SERIAL_SUB_OVF_EN, a=0x80, b=0x01 -> d=0x7F, bo=0, ovf=1.
REQ-031 SHALL check backpressure: out_ready held 0 for 5 cycles in DONE -> d/bo/out_valid stable, in_ready=0; in_valid ignored until after release.
REQ-032 SHALL check clrn pulsed low at SHIFT cycle 3 -> out_valid=0, d=0 immediately; next accepted operation a=0x7F, b=0x7F -> d=0x00, bo=0.
